sram_ahb: RTL and testbench

SRAM_AHB -- requirements
Module: sram_ahb

---
 rtl/sram_ahb_pkg.sv | 48 ++++
 rtl/sram_core.sv | 36 +++
 rtl/sram_ahb.sv | 188 ++++++++++++++++++
 tb/tb_sram_ahb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_ahb_pkg.sv
// Shared encodings for the AHB SRAM slave: HTRANS and HSIZE codes, FSM
// state encoding, and small decode helpers used by the bus front end.
package sram_ahb_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE codes (log2 of the transfer size in bytes)
    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // Slave FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are no-ops.
    function automatic logic trans_active(input logic [1:0] htrans);
        logic r;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: r = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  r = 1'b0;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Transfer size in bytes. Codes above a doubleword map to 128, which is
    // wider than any supported bus and therefore always decodes as an error.
    function automatic logic [7:0] size_bytes(input logic [2:0] hsize);
        logic [7:0] r;
        case (hsize)
            HSIZE_BYTE:  r = 8'd1;
            HSIZE_HALF:  r = 8'd2;
            HSIZE_WORD:  r = 8'd4;
            HSIZE_DWORD: r = 8'd8;
            default:     r = 8'd128;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_core.sv
// Synchronous SRAM array: per-byte write enables, one-cycle read latency.
// A write data phase can end on the same edge that accepts the next read's
// address phase, so the array takes separate write and read addresses on a
// single clock. Contents are not reset.
module sram_core #(
    parameter int DATA_W = 64,
    parameter int WORDS  = 512,
    parameter int AW     = 9
) (
    input  logic                CLK,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [WORDS];

    // Byte-masked write and registered read; a same-address read sees old data.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/sram_ahb.sv
// AHB-Lite SRAM slave. Fully pipelined: a new address phase is captured on
// the same edge the previous data phase completes. Optional wait states,
// two-cycle ERROR response for bad accesses, little-endian lane mapping and
// write-to-read forwarding for back-to-back access to the same word.
//
// Handshake: an address phase is taken on a rising edge where HSEL=1,
// HTRANS is NONSEQ/SEQ and HREADY=1. The data phase that follows completes
// on the first rising edge with HREADY=1; while HREADY=0 the master holds
// its address-phase signals and they are ignored here.
module sram_ahb
    import sram_ahb_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter int          RAM_BYTES   = 4096,
    parameter logic [63:0] RAM_START   = 64'h0002_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [63:0]       HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP
);

    localparam int BPW    = DATA_W / 8;
    localparam int LANE_W = $clog2(BPW);
    localparam int WORDS  = RAM_BYTES / BPW;
    localparam int AW     = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic              dp_valid_q, dp_valid_d;
    logic              dp_write_q, dp_write_d;
    logic [AW-1:0]     dp_word_q, dp_word_d;
    logic [BPW-1:0]    dp_mask_q, dp_mask_d;
    logic [BPW-1:0]    fwd_mask_q, fwd_mask_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              hready;
    logic              accept;
    logic              addr_err;
    logic [7:0]        sz8;
    logic [64:0]       sz_bytes;
    logic [63:0]       off_addr;
    logic [AW-1:0]     req_word;
    logic [LANE_W-1:0] req_lane;
    logic [BPW-1:0]    req_mask;
    logic              commit_wr;
    logic              rd_en;
    logic              rd_final;
    logic [DATA_W-1:0] ram_rdata;

    assign hready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HREADY = hready;
    assign HRESP  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    assign accept   = HSEL && trans_active(HTRANS) && hready;
    assign sz8      = size_bytes(HSIZE);
    assign sz_bytes = 65'(sz8);
    assign off_addr = HADDR - RAM_START;
    assign req_word = AW'(off_addr >> LANE_W);
    assign req_lane = HADDR[LANE_W-1:0];

    // Range, alignment and size checks on the incoming address phase;
    // 65-bit sums keep the end-of-window test free of wraparound.
    always_comb begin
        addr_err = 1'b0;
        if (HADDR < RAM_START) addr_err = 1'b1;
        if (({1'b0, HADDR} + sz_bytes) > ({1'b0, RAM_START} + 65'(RAM_BYTES))) addr_err = 1'b1;
        if ((HADDR & (sz_bytes[63:0] - 64'd1)) != 64'd0) addr_err = 1'b1;
        if (sz_bytes > 65'(BPW)) addr_err = 1'b1;
    end

    // Byte lanes touched by the incoming transfer.
    always_comb begin
        req_mask = '0;
        for (int i = 0; i < BPW; i++) begin
            req_mask[i] = (i >= int'(req_lane)) && (i < int'(req_lane) + int'(sz8));
        end
    end

    // FSM: ERR2 already drives HREADY=1, so it takes a new address phase
    // exactly as IDLE does instead of dropping it.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = 3'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q == 3'd0) state_d = ST_IDLE;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit_wr = dp_valid_q && dp_write_q && hready;
    assign rd_en     = accept && !addr_err && !HWRITE;
    assign rd_final  = dp_valid_q && !dp_write_q && hready;

    // Data-phase bookkeeping advances only when the current data phase ends;
    // forwarding state is captured when a read is issued to the array.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_word_d  = dp_word_q;
        dp_mask_d  = dp_mask_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        if (hready) begin
            dp_valid_d = accept && !addr_err;
            dp_write_d = HWRITE;
            dp_word_d  = req_word;
            dp_mask_d  = req_mask;
        end
        if (rd_en) begin
            fwd_mask_d = (commit_wr && (dp_word_q == req_word)) ? dp_mask_q : '0;
            fwd_data_d = HWDATA;
        end
    end

    // State registers; reset also drops any pending write so it never commits.
    always_ff @(posedge CLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= 3'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_word_q  <= '0;
            dp_mask_q  <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_word_q  <= dp_word_d;
            dp_mask_q  <= dp_mask_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    sram_core #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .AW     (AW)
    ) u_core (
        .CLK     (CLK),
        .we_i    (commit_wr),
        .be_i    (dp_mask_q),
        .waddr_i (dp_word_q),
        .wdata_i (HWDATA),
        .re_i    (rd_en),
        .raddr_i (req_word),
        .rdata_o (ram_rdata)
    );

    // Read data: forwarded lanes override the array, unaddressed lanes are 0,
    // and the bus is 0 outside the final cycle of an OKAY read.
    always_comb begin
        HRDATA = '0;
        for (int i = 0; i < BPW; i++) begin
            if (rd_final && dp_mask_q[i]) begin
                HRDATA[i*8 +: 8] = fwd_mask_q[i] ? fwd_data_q[i*8 +: 8] : ram_rdata[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_ahb.sv
// Directed bench for sram_ahb: one instance with no wait states and one with
// three, sharing the bus inputs. Expected values are hand-computed.
module tb_sram_ahb;

    logic        CLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] rdata0, rdata3;
    logic        ready0, ready3;
    logic        resp0, resp3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sram_ahb #(.WAIT_STATES(0)) dut0 (
        .CLK(CLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(rdata0),
        .HREADY(ready0), .HRESP(resp0)
    );

    sram_ahb #(.WAIT_STATES(3)) dut3 (
        .CLK(CLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(rdata3),
        .HREADY(ready3), .HRESP(resp3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [63:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = a;
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HADDR  = 64'd0;
    endtask

    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    // Single zero-wait transfer on dut0, data phase checked at the negedge.
    task automatic xfer0(input string tag, input logic wr, input logic [2:0] sz,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
        drive_addr(wr, sz, a);
        next_edge();
        drive_idle();
        HWDATA = wd;
        @(negedge CLK);
        chk({tag, ".ready"}, 64'(ready0), 64'd1);
        chk({tag, ".resp"},  64'(resp0),  64'd0);
        chk({tag, ".rdata"}, rdata0, exp_rd);
        next_edge();
    endtask

    // Erroring transfer on dut0: ERR1 then ERR2.
    task automatic err0(input string tag, input logic wr, input logic [2:0] sz,
                        input logic [63:0] a, input logic [63:0] wd);
        drive_addr(wr, sz, a);
        next_edge();
        drive_idle();
        HWDATA = wd;
        @(negedge CLK);
        chk({tag, ".err1_ready"}, 64'(ready0), 64'd0);
        chk({tag, ".err1_resp"},  64'(resp0),  64'd1);
        chk({tag, ".err1_rdata"}, rdata0, 64'd0);
        next_edge();
        @(negedge CLK);
        chk({tag, ".err2_ready"}, 64'(ready0), 64'd1);
        chk({tag, ".err2_resp"},  64'(resp0),  64'd1);
        next_edge();
    endtask

    // Single transfer on dut3: counts HREADY-low cycles (bounded) then checks data.
    task automatic xfer3(input string tag, input logic wr, input logic [2:0] sz,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd);
        int waits;
        drive_addr(wr, sz, a);
        next_edge();
        drive_idle();
        HWDATA = wd;
        waits = 0;
        @(negedge CLK);
        while (!ready3 && waits < 20) begin
            chk({tag, ".wait_rdata"}, rdata3, 64'd0);
            waits++;
            @(negedge CLK);
        end
        chk({tag, ".waits"}, 64'(waits), 64'd3);
        chk({tag, ".resp"},  64'(resp3), 64'd0);
        chk({tag, ".rdata"}, rdata3, exp_rd);
        next_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b0;
        drive_idle();
        HWDATA = 64'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst.ready0", 64'(ready0), 64'd1);
        chk("rst.resp0",  64'(resp0),  64'd0);
        chk("rst.rdata0", rdata0, 64'd0);
        chk("rst.ready3", 64'(ready3), 64'd1);
        chk("rst.rdata3", rdata3, 64'd0);
        HRESET = 1'b1;
        next_edge();

        // Word write then read back, zero wait
        xfer0("wr_word", 1'b1, 3'd3, 64'h2_0000, 64'h1122_3344_5566_7788, 64'd0);
        xfer0("rd_word", 1'b0, 3'd3, 64'h2_0000, 64'd0, 64'h1122_3344_5566_7788);

        // Byte write into lane 3 only; other HWDATA lanes are junk
        xfer0("wr_byte", 1'b1, 3'd0, 64'h2_0003, 64'hFFFF_FFFF_ABFF_FFFF, 64'd0);
        xfer0("rd_after_byte", 1'b0, 3'd3, 64'h2_0000, 64'd0, 64'h1122_3344_AB66_7788);
        xfer0("rd_hi_word", 1'b0, 3'd2, 64'h2_0004, 64'd0, 64'h1122_3344_0000_0000);
        xfer0("rd_half", 1'b0, 3'd1, 64'h2_0002, 64'd0, 64'h0000_0000_AB66_0000);

        // Error cases
        err0("err_below", 1'b0, 3'd3, 64'h1_FFF8, 64'd0);
        err0("err_misal", 1'b0, 3'd2, 64'h2_0002, 64'd0);
        err0("err_wr_misal", 1'b1, 3'd2, 64'h2_0002, 64'hFFFF_FFFF_FFFF_FFFF);
        err0("err_past_end", 1'b0, 3'd3, 64'h2_1000, 64'd0);
        err0("err_too_big", 1'b0, 3'd4, 64'h2_0000, 64'd0);
        xfer0("rd_unchanged", 1'b0, 3'd3, 64'h2_0000, 64'd0, 64'h1122_3344_AB66_7788);

        // Last word of the window
        xfer0("wr_last", 1'b1, 3'd3, 64'h2_0FF8, 64'h0123_4567_89AB_CDEF, 64'd0);
        xfer0("rd_last_hi", 1'b0, 3'd2, 64'h2_0FFC, 64'd0, 64'h0123_4567_0000_0000);

        // Back-to-back: write, read same word, byte write, read same word
        drive_addr(1'b1, 3'd3, 64'h2_0010);
        next_edge();
        HWDATA = 64'hDEAD_BEEF_0000_0001;
        drive_addr(1'b0, 3'd3, 64'h2_0010);
        @(negedge CLK);
        chk("b2b.wr_ready", 64'(ready0), 64'd1);
        chk("b2b.wr_rdata", rdata0, 64'd0);
        next_edge();
        HWDATA = 64'd0;
        drive_addr(1'b1, 3'd0, 64'h2_0011);
        @(negedge CLK);
        chk("b2b.rd_ready", 64'(ready0), 64'd1);
        chk("b2b.rd_rdata", rdata0, 64'hDEAD_BEEF_0000_0001);
        next_edge();
        HWDATA = 64'h0000_0000_0000_5A00;
        drive_addr(1'b0, 3'd3, 64'h2_0010);
        @(negedge CLK);
        chk("b2b.bwr_ready", 64'(ready0), 64'd1);
        next_edge();
        drive_idle();
        HWDATA = 64'd0;
        @(negedge CLK);
        chk("b2b.merge_ready", 64'(ready0), 64'd1);
        chk("b2b.merge_rdata", rdata0, 64'hDEAD_BEEF_0000_5A01);
        next_edge();
        xfer0("rd_b2b_ram", 1'b0, 3'd3, 64'h2_0010, 64'd0, 64'hDEAD_BEEF_0000_5A01);

        // Wait-state instance: clean start
        HRESET = 1'b0;
        next_edge();
        HRESET = 1'b1;
        next_edge();
        xfer3("w3_wr", 1'b1, 3'd3, 64'h2_0020, 64'hCAFE_F00D_1234_5678, 64'd0);
        xfer3("w3_rd", 1'b0, 3'd3, 64'h2_0020, 64'd0, 64'hCAFE_F00D_1234_5678);

        // Reset in the middle of a waited write
        drive_addr(1'b1, 3'd3, 64'h2_0020);
        next_edge();
        drive_idle();
        HWDATA = 64'h0BAD_0BAD_0BAD_0BAD;
        @(negedge CLK);
        chk("rstwait.ready_before", 64'(ready3), 64'd0);
        #2;
        HRESET = 1'b0;
        #1;
        chk("rstwait.ready", 64'(ready3), 64'd1);
        chk("rstwait.resp",  64'(resp3),  64'd0);
        chk("rstwait.rdata", rdata3, 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        HRESET = 1'b1;
        next_edge();
        xfer3("w3_rd_old", 1'b0, 3'd3, 64'h2_0020, 64'd0, 64'hCAFE_F00D_1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
